// File: rtl/pipe_stage_buf.sv
// Elastic pipeline-stage register: DEPTH-entry circular buffer, valid/ready, synchronous flush; 1-cycle in-to-out latency.
// Backpressure: in_ready = not full, from registered state only (no out_ready pass-through).
module pipe_stage_buf #(
  parameter int              WIDTH  = 32,
  parameter int              DEPTH  = 2,
  parameter logic [WIDTH-1:0] BUBBLE = '0,
  localparam int             PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int             CW     = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : BUBBLE;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Explicit wrap so non-power-of-two depths stay inside the array.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= in_data;
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: three instances (DEPTH 2, 1, 3) checked every cycle against a queue scoreboard.
module tb_pipe_stage_buf;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic resetn;

  logic a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [31:0] a_in_data, a_out_data;
  logic [1:0]  a_count;
  logic b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [31:0] b_in_data, b_out_data;
  logic [0:0]  b_count;
  logic c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic [31:0] c_in_data, c_out_data;
  logic [1:0]  c_count;

  pipe_stage_buf #(.WIDTH(32), .DEPTH(2), .BUBBLE(32'h0)) dut_a (
    .clk(clk), .resetn(resetn), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .count(a_count));
  pipe_stage_buf #(.WIDTH(32), .DEPTH(1), .BUBBLE(32'h0)) dut_b (
    .clk(clk), .resetn(resetn), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .count(b_count));
  pipe_stage_buf #(.WIDTH(32), .DEPTH(3), .BUBBLE(32'hDEAD)) dut_c (
    .clk(clk), .resetn(resetn), .flush(c_flush), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
    .count(c_count));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_state(input string nm, input int depth, input logic [31:0] bubble,
                           input int qsize, input logic [31:0] qhead, input logic ov,
                           input logic ir, input logic [31:0] od, input int cnt,
                           input int wp, input int rp);
    chk({nm, "_count"}, 32'(cnt), 32'(qsize));
    chk({nm, "_count_le_depth"}, 32'(cnt <= depth), 32'd1);
    chk({nm, "_out_valid"}, 32'(ov), 32'(qsize != 0));
    chk({nm, "_in_ready"}, 32'(ir), 32'(qsize != depth));
    chk({nm, "_out_data"}, od, (qsize != 0) ? qhead : bubble);
    chk({nm, "_ptr_rel"}, 32'((wp - rp + depth) % depth), 32'(cnt % depth));
  endtask

  // Scoreboard queues: expected buffer contents, updated on the same edge as the DUT.
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [31:0] qc[$];
  logic [31:0] b_seen[$];
  int          c_out_n = 0;
  logic        c_acc, c_pend;
  logic [31:0] c_pd;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      qa.delete(); qb.delete(); qc.delete();
      c_acc  <= 1'b0;
      c_pend <= 1'b0;
    end else begin
      if (a_flush) qa.delete();
      else if (a_in_valid && qa.size() != 2) begin
        if (qa.size() != 0 && a_out_ready) void'(qa.pop_front());
        qa.push_back(a_in_data);
      end else if (qa.size() != 0 && a_out_ready) void'(qa.pop_front());

      if (b_flush) qb.delete();
      else if (b_in_valid && qb.size() != 1) begin
        if (qb.size() != 0 && b_out_ready) void'(qb.pop_front());
        qb.push_back(b_in_data);
      end else if (qb.size() != 0 && b_out_ready) void'(qb.pop_front());

      if (c_pend) begin
        chk("c_in_valid_held", 32'(c_in_valid), 32'd1);
        chk("c_in_data_held", c_in_data, c_pd);
      end
      c_pend <= c_in_valid && qc.size() == 3 && !c_flush;
      c_pd   <= c_in_data;
      c_acc  <= c_in_valid && qc.size() != 3 && !c_flush;
      if (c_flush) qc.delete();
      else if (c_in_valid && qc.size() != 3) begin
        if (qc.size() != 0 && c_out_ready) void'(qc.pop_front());
        qc.push_back(c_in_data);
      end else if (qc.size() != 0 && c_out_ready) void'(qc.pop_front());
    end
  end

  // Monitor: compares every instance against its scoreboard on the falling edge.
  always @(negedge clk) begin
    if (resetn) begin
      chk_state("a", 2, 32'h0, qa.size(), (qa.size() != 0) ? qa[0] : 32'h0, a_out_valid,
                a_in_ready, a_out_data, int'(a_count), int'(dut_a.wr_ptr), int'(dut_a.rd_ptr));
      chk_state("b", 1, 32'h0, qb.size(), (qb.size() != 0) ? qb[0] : 32'h0, b_out_valid,
                b_in_ready, b_out_data, int'(b_count), int'(dut_b.wr_ptr), int'(dut_b.rd_ptr));
      chk_state("c", 3, 32'hDEAD, qc.size(), (qc.size() != 0) ? qc[0] : 32'h0, c_out_valid,
                c_in_ready, c_out_data, int'(c_count), int'(dut_c.wr_ptr), int'(dut_c.rd_ptr));
      if (b_out_valid && b_out_ready) b_seen.push_back(b_out_data);
      if (c_out_valid && c_out_ready) c_out_n++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          idx;
    int          nxt;
    logic        acc;
    resetn = 1'b0;
    {a_flush, a_in_valid, a_out_ready, b_flush, b_in_valid, b_out_ready} = '0;
    {c_flush, c_in_valid, c_out_ready} = '0;
    a_in_data = '0; b_in_data = '0; c_in_data = '0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    chk("rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_out_data", a_out_data, 32'h0);
    chk("rst_in_ready", 32'(a_in_ready), 32'd1);
    chk("rst_count", 32'(a_count), 32'd0);
    chk("rst_bubble_c", c_out_data, 32'hDEAD);

    // Fill to full, overfill is ignored, then drain.
    a_in_valid = 1'b1; a_in_data = 32'hA1; tick();
    a_in_data = 32'hA2; tick();
    chk("fill_count", 32'(a_count), 32'd2);
    chk("fill_in_ready", 32'(a_in_ready), 32'd0);
    chk("fill_head", a_out_data, 32'hA1);
    a_in_data = 32'hA3; tick();
    chk("overfill_count", 32'(a_count), 32'd2);
    chk("overfill_head", a_out_data, 32'hA1);
    a_in_valid = 1'b0; a_out_ready = 1'b1; tick();
    chk("drain_head2", a_out_data, 32'hA2);
    tick();
    chk("drain_empty_valid", 32'(a_out_valid), 32'd0);
    chk("drain_empty_data", a_out_data, 32'h0);
    a_out_ready = 1'b0;

    // Asynchronous reset mid-cycle with an entry held.
    a_in_valid = 1'b1; a_in_data = 32'hB5; tick();
    a_in_valid = 1'b0;
    chk("pre_reset_count", 32'(a_count), 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_valid", 32'(a_out_valid), 32'd0);
    chk("async_rst_data", a_out_data, 32'h0);
    chk("async_rst_ready", 32'(a_in_ready), 32'd1);
    chk("async_rst_count", 32'(a_count), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    tick();

    // Streaming 1..8 at full rate.
    a_in_valid = 1'b1; a_out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      a_in_data = 32'(i);
      tick();
      chk("stream_count", 32'(a_count), 32'd1);
      chk("stream_head", a_out_data, 32'(i));
    end
    a_in_valid = 1'b0; tick();
    chk("stream_end_count", 32'(a_count), 32'd0);
    a_out_ready = 1'b0;

    // Flush with a concurrent push.
    a_in_valid = 1'b1; a_in_data = 32'h10; tick();
    a_in_data = 32'h11; tick();
    chk("preflush_count", 32'(a_count), 32'd2);
    a_flush = 1'b1; a_in_data = 32'h12; tick();
    a_flush = 1'b0; a_in_valid = 1'b0;
    chk("flush_count", 32'(a_count), 32'd0);
    chk("flush_valid", 32'(a_out_valid), 32'd0);
    chk("flush_data", a_out_data, 32'h0);
    a_in_valid = 1'b1; a_in_data = 32'h13; tick();
    a_in_valid = 1'b0;
    chk("postflush_head", a_out_data, 32'h13);
    chk("postflush_count", 32'(a_count), 32'd1);
    a_out_ready = 1'b1; tick();
    chk("postflush_empty", 32'(a_out_valid), 32'd0);
    a_out_ready = 1'b0;

    // DEPTH=1: accepts on alternate cycles only.
    b_in_valid = 1'b1; b_out_ready = 1'b1; idx = 1;
    for (int cyc = 0; cyc < 16 && idx <= 4; cyc++) begin
      b_in_data = 32'(idx);
      acc = b_in_ready;
      tick();
      if (acc) begin
        chk("b_accept_cycle", 32'(cyc), 32'(2 * (idx - 1)));
        idx++;
      end
    end
    b_in_valid = 1'b0;
    chk("b_all_accepted", 32'(idx), 32'd5);
    tick(); tick();
    chk("b_out_n", 32'(b_seen.size()), 32'd4);
    if (b_seen.size() == 4)
      for (int i = 0; i < 4; i++) chk("b_out_order", b_seen[i], 32'(i + 1));

    // DEPTH=3 random traffic; producer holds each payload until accepted.
    nxt = 1;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      if (c_in_valid && c_acc) c_in_valid = 1'b0;
      if (!c_in_valid && $urandom_range(0, 2) != 0) begin
        c_in_valid = 1'b1;
        c_in_data  = 32'(nxt);
        nxt++;
      end
      c_out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    c_out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (c_in_valid && c_acc) c_in_valid = 1'b0;
      if (!c_in_valid) break;
      tick();
    end
    chk("c_producer_drained", 32'(c_in_valid), 32'd0);
    c_in_valid = 1'b0;
    repeat (5) tick();
    chk("c_out_total", 32'(c_out_n), 32'(nxt - 1));
    chk("c_final_empty_data", c_out_data, 32'hDEAD);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
